// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: FSM state encoding
// and the default parameter values used by regfile_mp and regfile_rdport.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_NUM_RD   = 2;
  localparam int DEF_ZERO_REG = 1;

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port of regfile_mp: zero-gating while the clear
// sequence runs, hard-wired zero for register 0, and optional same-cycle
// write forwarding when REGFILE_MP_BYPASS_EN is defined.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input  logic              i_busy,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic [DATA_W-1:0] i_mem_data,
  input  logic              i_wr_ok,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0] o_rd_data
);

  logic w_zero_hit;
  assign w_zero_hit = (ZERO_REG != 0) && (i_rd_addr == '0);

`ifdef REGFILE_MP_BYPASS_EN
  // Forward the in-flight write; i_wr_ok already excludes CLEAR and reg 0.
  always_comb begin
    o_rd_data = i_mem_data;
    if (i_busy || w_zero_hit) begin
      o_rd_data = '0;
    end else if (i_wr_ok && (i_wr_addr == i_rd_addr)) begin
      o_rd_data = i_wr_data;
    end
  end
`else
  // Write data only becomes visible after the edge, so the write port is unused here.
  logic w_unused;
  assign w_unused = ^{i_wr_ok, i_wr_addr, i_wr_data};

  // Plain storage read with busy and register-0 gating.
  always_comb begin
    o_rd_data = i_mem_data;
    if (i_busy || w_zero_hit) begin
      o_rd_data = '0;
    end
  end
`endif

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: one write port, NUM_RD combinational read ports.
// After reset a CLEAR sequence zeroes every entry (busy=1), then the block
// goes READY. Writes arriving while busy are dropped and flagged on wr_drop
// one cycle later. Optional feature macro: REGFILE_MP_BYPASS_EN enables
// same-cycle write-to-read forwarding.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic                     busy,
  output logic                     wr_drop
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_idx;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_wr_drop;
  logic              w_busy;
  logic              w_wr_ok;

  assign w_busy  = (r_state == CLEAR);
  assign busy    = w_busy;
  assign wr_drop = r_wr_drop;

  // Accepted user write: only in READY, and never to the hard-wired zero register.
  assign w_wr_ok = wr_en && !w_busy && !((ZERO_REG != 0) && (wr_addr == '0));

  // State register; reset always restarts the clear sequence.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: leave CLEAR on the cycle that clears the last index.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CLEAR:   if (&r_clr_idx) w_state_nxt = READY;
      READY:   w_state_nxt = READY;
      default: w_state_nxt = CLEAR;
    endcase
  end

  // Clear index walks 0..DEPTH-1 while clearing and parks at 0 once it wraps.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_clr_idx <= '0;
    end else if (w_busy) begin
      r_clr_idx <= r_clr_idx + 1'b1;
    end
  end

  // Drop flag: a write request seen during CLEAR is reported for one cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_drop <= 1'b0;
    end else begin
      r_wr_drop <= wr_en && w_busy;
    end
  end

  // Storage: clear writes win in CLEAR, user writes in READY; reset blocks both.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (w_busy) begin
        r_mem[r_clr_idx] <= '0;
      end else if (w_wr_ok) begin
        r_mem[wr_addr] <= wr_data;
      end
    end
  end

  // One independent read mux per port.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    assign w_ra = rd_addr[k*ADDR_W +: ADDR_W];

    regfile_rdport #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_rdport (
      .i_busy     (w_busy),
      .i_rd_addr  (w_ra),
      .i_mem_data (r_mem[w_ra]),
      .i_wr_ok    (w_wr_ok),
      .i_wr_addr  (wr_addr),
      .i_wr_data  (wr_data),
      .o_rd_data  (rd_data[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp (default parameters). A driver applies one
// input vector per cycle, predicts the outputs from a behavioural model and
// queues the prediction; a monitor on the falling edge pops and compares.
module tb_regfile_mp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int ZERO   = 1;
  localparam int DEPTH  = 32;
`ifdef REGFILE_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                     clock = 1'b0;
  logic                     reset;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     busy;
  logic                     wr_drop;

  regfile_mp #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy),
    .wr_drop (wr_drop)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic                     busy;
    logic                     drop;
    logic [NUM_RD*DATA_W-1:0] rd;
    logic [31:0]              cyc;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc_n = 0;

  // Behavioural model state
  logic [DATA_W-1:0] m_mem [DEPTH];
  int                m_busy_cnt;
  bit                m_drop;
  // Inputs of the previous cycle, consumed by the model at each rising edge
  bit                p_rst, p_we;
  int                p_wa;
  logic [DATA_W-1:0] p_wd;

  function automatic bool_zero(input int a);
    return (ZERO != 0) && (a == 0);
  endfunction

  task automatic model_edge();
    if (p_rst) begin
      m_busy_cnt = DEPTH;
      m_drop     = 1'b0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    end else begin
      m_drop = p_we && (m_busy_cnt > 0);
      if (m_busy_cnt > 0) m_busy_cnt--;
      else if (p_we && !bool_zero(p_wa)) m_mem[p_wa] = p_wd;
    end
  endtask

  function automatic logic [DATA_W-1:0] model_read(input int ra, input bit we,
                                                   input int wa, input logic [DATA_W-1:0] wd);
    if (m_busy_cnt > 0 || bool_zero(ra)) return '0;
    if (BYP && we && wa == ra && !bool_zero(wa)) return wd;
    return m_mem[ra];
  endfunction

  // One clock cycle: update model for the edge, apply new inputs, queue prediction.
  task automatic cyc(input bit rst, input bit we, input int wa,
                     input logic [DATA_W-1:0] wd, input int ra0, input int ra1);
    exp_t e;
    @(posedge clock);
    model_edge();
    #1;
    reset   = rst;
    wr_en   = we;
    wr_addr = ADDR_W'(wa);
    wr_data = wd;
    rd_addr = {ADDR_W'(ra1), ADDR_W'(ra0)};
    e.busy  = (m_busy_cnt > 0);
    e.drop  = m_drop;
    e.rd    = {model_read(ra1, we, wa, wd), model_read(ra0, we, wa, wd)};
    e.cyc   = 32'(cyc_n);
    q.push_back(e);
    cyc_n++;
    p_rst = rst; p_we = we; p_wa = wa; p_wd = wd;
  endtask

  task automatic idle(input int n, input int ra0, input int ra1);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, '0, ra0, ra1);
  endtask

  // Monitor: compare every queued prediction with what the DUT presents.
  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_vec++;
      if (busy !== e.busy) begin
        n_err++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", e.cyc, busy, e.busy);
      end
      n_vec++;
      if (wr_drop !== e.drop) begin
        n_err++;
        $display("FAIL wr_drop cyc=%0d got=%b exp=%b", e.cyc, wr_drop, e.drop);
      end
      for (int k = 0; k < NUM_RD; k++) begin
        n_vec++;
        if (rd_data[k*DATA_W +: DATA_W] !== e.rd[k*DATA_W +: DATA_W]) begin
          n_err++;
          $display("FAIL rd_data[%0d] cyc=%0d got=%h exp=%h", k, e.cyc,
                   rd_data[k*DATA_W +: DATA_W], e.rd[k*DATA_W +: DATA_W]);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    p_rst = 1'b1; p_we = 1'b0; p_wa = 0; p_wd = '0;
    m_busy_cnt = DEPTH; m_drop = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    repeat (2) @(posedge clock);

    // Clear after reset; a write at clear cycle 5 must be dropped.
    idle(5, 9, 31);
    cyc(1'b0, 1'b1, 9, 32'hCAFE_F00D, 9, 9);
    idle(DEPTH - 6, 9, 1);
    // All registers read 0 after the clear.
    for (int i = 0; i < DEPTH; i += 2) idle(1, i, i + 1);

    // Write then read on both ports at the same address.
    cyc(1'b0, 1'b1, 7, 32'hDEAD_BEEF, 7, 7);
    idle(1, 7, 7);
    // Register 0 ignores writes without a drop.
    cyc(1'b0, 1'b1, 0, 32'h1234_5678, 0, 7);
    idle(2, 0, 0);
    // Same-cycle write/read of reg 3 holding 1.
    cyc(1'b0, 1'b1, 3, 32'h1, 3, 0);
    cyc(1'b0, 1'b1, 3, 32'hA5A5_A5A5, 3, 3);
    idle(1, 3, 7);

    // Reset, then a second reset pulse at clear cycle 20.
    cyc(1'b1, 1'b1, 5, 32'h5555_0000, 5, 7);
    idle(20, 7, 3);
    cyc(1'b1, 1'b0, 0, '0, 7, 3);
    for (int i = 0; i < DEPTH + 2; i++)
      cyc(1'b0, ($urandom_range(3) == 0), $urandom_range(DEPTH - 1), $urandom,
          $urandom_range(DEPTH - 1), $urandom_range(DEPTH - 1));

    // Randomized traffic with occasional resets and address collisions.
    for (int i = 0; i < 600; i++) begin
      int wa, r0, r1;
      wa = $urandom_range(DEPTH - 1);
      r0 = ($urandom_range(3) == 0) ? wa : $urandom_range(DEPTH - 1);
      r1 = ($urandom_range(3) == 0) ? r0 : $urandom_range(DEPTH - 1);
      cyc(($urandom_range(199) == 0), ($urandom_range(1) == 1), wa, $urandom, r0, r1);
    end

    @(posedge clock);
    @(negedge clock);
    #1;
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning the address width; DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter NUM_RD, default 2, meaning the number of read ports (range 1..4).
REQ-004 SHALL have parameter ZERO_REG, default 1, meaning that when 1, register 0 always reads 0 and ignores writes.
REQ-005 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port wr_en, input, 1 bit: write request.
REQ-008 SHALL have port wr_addr, input, ADDR_W bits: write index.
REQ-009 SHALL have port wr_data, input, DATA_W bits: write data.
REQ-010 SHALL have port rd_addr, input, NUM_RD*ADDR_W bits: packed read indices, port k at bits [k*ADDR_W +: ADDR_W].
REQ-011 SHALL have port rd_data, output, NUM_RD*DATA_W bits: packed read data, port k at bits [k*DATA_W +: DATA_W].
REQ-012 SHALL have port busy, output, 1 bit: clear sequence in progress.
REQ-013 SHALL have port wr_drop, output, 1 bit: registered pulse, meaning the previous cycle's write was discarded.

Function
REQ-014 SHALL implement a two-state FSM: CLEAR and READY.
REQ-015 In CLEAR, the block SHALL write 0 to mem[clr_idx] each cycle and increment clr_idx; on the cycle that clears index DEPTH-1, the next state SHALL be READY.
REQ-016 busy SHALL be 1 in CLEAR and 0 in READY, decoded directly from state.
REQ-017 In READY, wr_en=1 SHALL write wr_data to mem[wr_addr] at the rising edge, except address 0 when ZERO_REG=1.
REQ-018 A write with wr_en=1 while busy=1 SHALL be discarded, and wr_drop SHALL be 1 in the following cycle only.
REQ-019 A write to address 0 with ZERO_REG=1 SHALL be silently ignored and SHALL NOT assert wr_drop.
REQ-020 Reads SHALL be combinational: rd_data[k] = mem[rd_addr[k]], with 0 latency.
REQ-021 rd_data SHALL be 0 for address 0 when ZERO_REG=1, and 0 on all ports while busy=1.
REQ-022 All read ports SHALL be independent; identical addresses on several ports SHALL return identical data.
REQ-023 The write port SHALL have write-first-next-cycle semantics: a read in the write cycle returns the old value, except as given under Configuration.

Reset
REQ-024 While reset=1, at each edge the block SHALL force state=CLEAR, clr_idx=0 and wr_drop=0; memory contents are don't-care until cleared.
REQ-025 busy SHALL be 1 during reset and for exactly DEPTH cycles after reset deasserts.
REQ-026 Reset asserted mid-clear SHALL restart clearing from index 0.
REQ-027 Reset SHALL have priority over wr_en.

Configuration
REQ-028 Macro REGFILE_MP_BYPASS_EN defined: in READY, if wr_en=1 and wr_addr==rd_addr[k] (and not address 0 when ZERO_REG=1), rd_data[k] SHALL equal wr_data in the same cycle.
REQ-029 Macro REGFILE_MP_BYPASS_EN undefined: no forwarding; REQ-023 SHALL apply unconditionally.

Structure
REQ-030 A shared package regfile_pkg SHALL hold the FSM state typedef (CLEAR, READY) and the default parameter constants.
REQ-031 The read-port mux, including bypass and zero-gating, SHALL be one sub-module, regfile_rdport, instantiated NUM_RD times in a generate loop.
REQ-032 Storage, the FSM and clr_idx SHALL reside in regfile_mp.

Verification
REQ-033 Reset released at t0 (defaults) -> busy=1 for 32 cycles, then busy=0; every register reads 0.
REQ-034 READY: write 0xDEADBEEF to reg 7, next cycle read port 0 at 7 and port 1 at 7 -> both return 0xDEADBEEF.
REQ-035 Write 0x12345678 to reg 0 -> reads 0, wr_drop=0; same test with ZERO_REG=0 -> reads 0x12345678.
REQ-036 wr_en=1 at cycle 5 of clear -> next cycle wr_drop=1 for exactly one cycle; the target register reads 0 after clear.
REQ-037 Reset pulsed at clear cycle 20 -> busy remains 1 for 32 further cycles after release.
REQ-038 Same-cycle write of 0xA5A5A5A5 to reg 3 and read of 3 (reg holding 0x1) -> returns 0xA5A5A5A5 with REGFILE_MP_BYPASS_EN defined, 0x1 without it.
